// File: rtl/kernel_pio_gen_pkg.sv
// Shared constants for the kernel PIO slave: register map, edge polarity and irq source.
package kernel_pio_pkg;

   localparam logic [2:0] PIO_DATA    = 3'd0;
   localparam logic [2:0] PIO_DIR     = 3'd1;
   localparam logic [2:0] PIO_IRQMASK = 3'd2;
   localparam logic [2:0] PIO_EDGECAP = 3'd3;
   localparam logic [2:0] PIO_OUTSET  = 3'd4;
   localparam logic [2:0] PIO_OUTCLR  = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   localparam int IRQ_EDGE  = 0;
   localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/kernel_pio_gen_if.sv
// Avalon-MM slave bus bundle for the kernel PIO: the CPU side is the master.
interface kernel_pio_gen_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/kernel_pio_gen_edge_sync.sv
// Multi-flop pin synchroniser, one-cycle history flop and per-bit edge detector.
module pio_edge_sync
   import kernel_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
   logic [WIDTH-1:0]                  prev_reg;

   // Stage 0 takes the raw pins; the last stage is the usable synchronised value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_reg <= '0;
         prev_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign sync_in = sync_reg[SYNC_STAGES-1];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
         assign edge_pulse[gi] = ~sync_in[gi] & prev_reg[gi];
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
         assign edge_pulse[gi] = sync_in[gi] ^ prev_reg[gi];
      end else begin : g_rise
         assign edge_pulse[gi] = sync_in[gi] & ~prev_reg[gi];
      end
   end

endmodule

// File: rtl/kernel_pio_gen.sv
// Kernel PIO slave: register file, registered read mux and interrupt generation.
module kernel_pio_gen
   import kernel_pio_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_TYPE   = EDGE_RISING,
   parameter int          IRQ_MODE    = IRQ_EDGE,
   parameter logic [31:0] OUT_RESET   = 32'h0
) (
   input  logic             clk,
   input  logic             reset_n,
   kernel_pio_gen_if.slave  bus,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   logic [WIDTH-1:0] sync_in, edge_pulse;
   logic [WIDTH-1:0] out_reg, out_next;
   logic [WIDTH-1:0] dir_reg, dir_next;
   logic [WIDTH-1:0] mask_reg, mask_next;
   logic [WIDTH-1:0] cap_reg, cap_next;
   logic [31:0]      readdata_reg, readdata_next;
   logic [WIDTH-1:0] wdata;
   logic             wr_en;

   wire unused_wdata = ^{1'b0, bus.writedata};

   pio_edge_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_edge_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .sync_in    (sync_in),
      .edge_pulse (edge_pulse)
   );

   assign wr_en = bus.chipselect && !bus.write_n;
   assign wdata = bus.writedata[WIDTH-1:0];

   always_comb begin
      out_next  = out_reg;
      dir_next  = dir_reg;
      mask_next = mask_reg;
      cap_next  = cap_reg;
      if (wr_en) begin
         case (bus.address)
            PIO_DATA:    out_next  = wdata;
            PIO_DIR:     dir_next  = wdata;
            PIO_IRQMASK: mask_next = wdata;
            PIO_EDGECAP: cap_next  = cap_reg & ~wdata;
            PIO_OUTSET:  out_next  = out_reg | wdata;
            PIO_OUTCLR:  out_next  = out_reg & ~wdata;
            default:     ;
         endcase
      end
      // A fresh edge overrides a same-cycle clear so no event is lost.
      cap_next = cap_next | edge_pulse;
   end

   always_comb begin
      readdata_next = '0;
      case (bus.address)
         PIO_DATA:    readdata_next[WIDTH-1:0] = sync_in;
         PIO_DIR:     readdata_next[WIDTH-1:0] = dir_reg;
         PIO_IRQMASK: readdata_next[WIDTH-1:0] = mask_reg;
         PIO_EDGECAP: readdata_next[WIDTH-1:0] = cap_reg;
         default:     ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_reg      <= OUT_RESET[WIDTH-1:0];
         dir_reg      <= '0;
         mask_reg     <= '0;
         cap_reg      <= '0;
         readdata_reg <= '0;
      end else begin
         out_reg      <= out_next;
         dir_reg      <= dir_next;
         mask_reg     <= mask_next;
         cap_reg      <= cap_next;
         readdata_reg <= readdata_next;
      end
   end

   assign bus.readdata = readdata_reg;
   assign out_port     = out_reg;
   assign oe           = dir_reg;

   if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
      assign irq = |(sync_in & mask_reg);
   end else begin : g_irq_edge
      assign irq = |(cap_reg & mask_reg);
   end

endmodule

// File: tb/tb_kernel_pio_gen.sv
// Directed bench: dut0 is rising-edge/edge-irq with OUT_RESET=A5, dut1 is any-edge/level-irq.
module tb_kernel_pio_gen;
   import kernel_pio_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_port0, in_port1;
   logic [7:0] out_port0, out_port1, oe0, oe1;
   logic       irq0, irq1;
   int         vectors = 0;
   int         miscompares = 0;

   kernel_pio_gen_if bus0();
   kernel_pio_gen_if bus1();

   always #5 clk = ~clk;

   kernel_pio_gen #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING),
                    .IRQ_MODE(IRQ_EDGE), .OUT_RESET(32'hA5)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port0),
      .out_port(out_port0), .oe(oe0), .irq(irq0));

   kernel_pio_gen #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY),
                    .IRQ_MODE(IRQ_LEVEL), .OUT_RESET(32'h0)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port1),
      .out_port(out_port1), .oe(oe1), .irq(irq1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr0(input logic [2:0] addr, input logic [31:0] data);
      bus0.address = addr; bus0.writedata = data;
      bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
      tick(1);
      bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
   endtask

   task automatic wr1(input logic [2:0] addr, input logic [31:0] data);
      bus1.address = addr; bus1.writedata = data;
      bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
      tick(1);
      bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
   endtask

   task automatic rd0(input logic [2:0] addr, input logic [31:0] exp, input string tag);
      bus0.address = addr;
      tick(1);
      check(tag, bus0.readdata, exp);
   endtask

   task automatic rd1(input logic [2:0] addr, input logic [31:0] exp, input string tag);
      bus1.address = addr;
      tick(1);
      check(tag, bus1.readdata, exp);
   endtask

   initial begin
      reset_n = 1'b0;
      in_port0 = 8'h00; in_port1 = 8'h00;
      bus0.address = 3'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
      bus1.address = 3'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
      tick(2);

      // Reset state
      check("rst_out0", {24'h0, out_port0}, 32'hA5);
      check("rst_oe0", {24'h0, oe0}, 32'h0);
      check("rst_rd0", bus0.readdata, 32'h0);
      check("rst_irq0", {31'h0, irq0}, 32'h0);
      check("rst_out1", {24'h0, out_port1}, 32'h0);
      reset_n = 1'b1;
      for (int a = 1; a < 8; a++) rd0(a[2:0], 32'h0, $sformatf("rst_addr%0d", a));
      in_port0 = 8'h81;
      tick(2);
      rd0(PIO_DATA, 32'h81, "rst_data_pins");
      wr0(PIO_EDGECAP, 32'hFF);
      in_port0 = 8'h00;
      tick(3);
      rd0(PIO_EDGECAP, 32'h0, "fall_ignored_b0b7");

      // Rising edge on bit 2 with mask 04
      wr0(PIO_IRQMASK, 32'h04);
      in_port0 = 8'h04;
      tick(2);
      check("irq_before_cap", {31'h0, irq0}, 32'h0);
      tick(1);
      check("irq_after_cap", {31'h0, irq0}, 32'h1);
      rd0(PIO_EDGECAP, 32'h04, "cap_bit2");
      wr0(PIO_EDGECAP, 32'h04);
      check("irq_cleared", {31'h0, irq0}, 32'h0);
      in_port0 = 8'h00;
      tick(4);
      rd0(PIO_EDGECAP, 32'h0, "cap_fall_bit2");
      check("irq_fall_bit2", {31'h0, irq0}, 32'h0);

      // W1C collides with an edge on bit 1: the edge wins
      in_port0 = 8'h02;
      tick(2);
      wr0(PIO_EDGECAP, 32'h02);
      rd0(PIO_EDGECAP, 32'h02, "collision_keep");
      wr0(PIO_EDGECAP, 32'h02);
      rd0(PIO_EDGECAP, 32'h0, "w1c_clear");

      // Atomic output set/clear, direction
      wr0(PIO_DATA, 32'h0F);
      check("out_data", {24'h0, out_port0}, 32'h0F);
      wr0(PIO_OUTSET, 32'h30);
      check("out_set", {24'h0, out_port0}, 32'h3F);
      wr0(PIO_OUTCLR, 32'h03);
      check("out_clr", {24'h0, out_port0}, 32'h3C);
      rd0(PIO_DATA, 32'h02, "data_reads_pins");
      rd0(PIO_OUTSET, 32'h0, "outset_reads0");
      rd0(PIO_OUTCLR, 32'h0, "outclr_reads0");
      wr0(PIO_DIR, 32'hFFFF_FFF0);
      check("oe_dir", {24'h0, oe0}, 32'hF0);
      rd0(PIO_DIR, 32'hF0, "dir_readback");

      // Read latency
      wr0(PIO_IRQMASK, 32'h5A);
      rd0(3'd6, 32'h0, "addr6_reads0");
      bus0.address = PIO_IRQMASK;
      #1 check("rd_not_early", bus0.readdata, 32'h0);
      tick(1);
      check("rd_latency1", bus0.readdata, 32'h5A);

      // Any-edge capture, level irq on dut1
      wr1(PIO_IRQMASK, 32'h80);
      in_port1 = 8'h80;
      tick(1);
      check("lvl_irq_d1", {31'h0, irq1}, 32'h0);
      tick(1);
      check("lvl_irq_d2", {31'h0, irq1}, 32'h1);
      tick(1);
      rd1(PIO_EDGECAP, 32'h80, "any_rise_b7");
      wr1(PIO_EDGECAP, 32'h80);
      rd1(PIO_EDGECAP, 32'h0, "any_cleared");
      in_port1 = 8'h00;
      tick(1);
      check("lvl_irq_hold", {31'h0, irq1}, 32'h1);
      tick(1);
      check("lvl_irq_low", {31'h0, irq1}, 32'h0);
      tick(1);
      rd1(PIO_EDGECAP, 32'h80, "any_fall_b7");

      // Reset with a write pending discards it; held-high pin captures afterwards
      bus0.address = PIO_DIR; bus0.writedata = 32'h0F;
      bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
      reset_n = 1'b0;
      tick(1);
      bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
      check("rst_discard_oe", {24'h0, oe0}, 32'h0);
      check("rst_out_again", {24'h0, out_port0}, 32'hA5);
      reset_n = 1'b1;
      bus0.address = PIO_EDGECAP;
      tick(4);
      check("post_rst_rise", bus0.readdata, 32'h02);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/kernel_pio_gen.md
Name: kernel_pio_gen

Overview:
Parametrised Avalon-MM parallel I/O slave for the kernel subsystem. It provides WIDTH bidirectional-capable bits, a multi-flop input synchroniser and per-bit edge capture with compile-time edge polarity. It also has per-bit interrupt masking, write-1-to-clear capture, and atomic output set/clear registers. It sits on the kernel interconnect beside the timer and UART slaves and drives one irq line to the CPU.

Parameters:
WIDTH, 8, number of I/O bits (1..32)
SYNC_STAGES, 2, input synchroniser depth (2..4)
EDGE_TYPE, 0, 0 rising, 1 falling, 2 any edge
IRQ_MODE, 0, 0 edge (from capture register), 1 level (from synchronised input)
OUT_RESET, 0, reset value of the output data register (WIDTH bits, zero-extended)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  write strobe, active-low
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  asynchronous pin inputs
out_port  out  WIDTH  output data register
oe  out  WIDTH  per-bit direction, 1 = drive
irq  out  1  interrupt request

Behaviour:
- Write occurs when chipselect=1 and write_n=0. Only bits [WIDTH-1:0] of writedata are used. Upper readdata bits always read 0.
- Register map:
  - 0 DATA: read returns the synchronised input; write loads out_port.
  - 1 DIR: read/write; drives oe.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns capture; write clears each bit where writedata=1.
  - 4 OUTSET: write ORs writedata into out_port; reads 0.
  - 5 OUTCLR: write clears out_port bits where writedata=1; reads 0.
  - 6-7: read 0, writes ignored.
- readdata is registered every clk from the current address, independent of chipselect. Read latency is 1 cycle.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_in. One further flop gives prev_in.
- Edge detection per bit:
  - rising: sync_in & ~prev_in
  - falling: ~sync_in & prev_in
  - any: sync_in ^ prev_in
- Latency: a pin change appears in sync_in after SYNC_STAGES clocks. The capture bit sets 1 clock after that.
- EDGECAP: a detected edge sets the bit, and the bit holds until cleared by a W1C write. If a W1C write and an edge hit the same bit in the same cycle, the edge wins and the bit stays 1.
- irq:
  - IRQ_MODE=0: irq = |(edgecap & irqmask)
  - IRQ_MODE=1: irq = |(sync_in & irqmask)
  - irq is combinational from registers, with no extra latency.
- Reset (reset_n=0 at a clk edge):
  - Sampled at the edge: readdata=0, out_port=OUT_RESET, oe=0, irqmask=0, edgecap=0, synchroniser and prev_in flops=0, irq=0.
  - Reset mid-transaction discards the write.
  - After reset release, edges arising from the zeroed synchroniser are real and are captured: a pin held high gives a rising capture on bits with EDGE_TYPE 0/2.
- Writes to different registers are never simultaneous. OUTSET/OUTCLR take effect at the next clk edge, as DATA writes do.

Decomposition:
- Package kernel_pio_pkg holds:
  - register address constants PIO_DATA..PIO_OUTCLR
  - edge-type constants EDGE_RISING/EDGE_FALLING/EDGE_ANY
  - irq-mode constants
- Sub-module pio_edge_sync: a WIDTH-wide synchroniser plus prev flop and edge detect, parameterised by SYNC_STAGES and EDGE_TYPE. It outputs sync_in and edge_pulse.
- Top level holds the register file, read mux and irq.

Test Plan:
1. Reset: reset_n=0 for 2 clk with OUT_RESET=8'hA5 -> out_port=8'hA5, oe=0, readdata=0, irq=0. Every address reads 0 except DATA, which reads the synchronised pins.
2. Rising edge, WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0, IRQMASK=8'h04: raise in_port[2] -> EDGECAP=8'h04 three clks later and irq=1. Write EDGECAP=8'h04 -> irq=0 next clk. A falling edge on bit 2 does not set it.
3. Collision: arrange an edge on bit 1 in the same cycle as a W1C write of 8'h02 -> EDGECAP[1] stays 1.
4. Atomic output: out_port=8'h0F. Write OUTSET=8'h30 -> 8'h3F. Write OUTCLR=8'h03 -> 8'h3C. Read DATA returns pins, not out_port.
5. EDGE_TYPE=2, IRQ_MODE=1: toggling bit 7 sets EDGECAP[7] on both edges. With IRQMASK=8'h80, irq follows the synchronised bit 7 level, delayed by 2 clk.
6. Read latency: address=2 after writing IRQMASK=8'h5A -> readdata=32'h0000005A exactly 1 clk later. Address 6 -> 0.
